pipe_ctrl: RTL

Pipeline sequencing controller for the five-stage MIPS32 core. It merges stall requests from the decode and execute stages, sequences multi-cycle execute operations (divide, multiply-accumulate) with an internal down-counter, and converts exception requests into a one-cycle pipeline flush with a redirect PC. Its outputs drive the hold/flush inputs of the pc, if_id, id_ex, ex_mem and mem_wb registers.

---
 rtl/pipe_ctrl_if.sv | 28 ++
 rtl/pipe_ctrl.sv | 75 +++++++
 2 files changed

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages and the sequencing controller.
// The slave modport is the controller side; the master modport is the stage side.
interface pipe_ctrl_if #(
    parameter int MC_CNT_W = 6,
    parameter int PC_W     = 32
);
    logic                stallreq_id;
    logic                stallreq_ex;
    logic                mc_start;
    logic [MC_CNT_W-1:0] mc_cycles;
    logic                excp_req;
    logic [PC_W-1:0]     excp_handler;
    logic [5:0]          stall;
    logic                flush;
    logic [PC_W-1:0]     new_pc;
    logic                mc_done;
    logic                busy;

    modport slave (
        input  stallreq_id, stallreq_ex, mc_start, mc_cycles, excp_req, excp_handler,
        output stall, flush, new_pc, mc_done, busy
    );

    modport master (
        output stallreq_id, stallreq_ex, mc_start, mc_cycles, excp_req, excp_handler,
        input  stall, flush, new_pc, mc_done, busy
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: merges stall requests, counts out multi-cycle
// execute operations and turns exceptions into a one-cycle flush with redirect PC.
module pipe_ctrl #(
    parameter int MC_CNT_W = 6,
    parameter int PC_W     = 32
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BUSY, FLUSH} state_t;

    localparam logic [MC_CNT_W-1:0] CNT_ONE = MC_CNT_W'(1);

    state_t              r_state, w_state_nxt;
    logic [MC_CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [PC_W-1:0]     r_new_pc, w_new_pc_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_new_pc <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_new_pc <= w_new_pc_nxt;
        end
    end

    // new_pc is only loaded on the edge that enters FLUSH, so it reads 0 elsewhere.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_new_pc_nxt = '0;
        if (bus.excp_req) begin
            w_state_nxt  = FLUSH;
            w_cnt_nxt    = '0;
            w_new_pc_nxt = bus.excp_handler;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.mc_start) begin
                        w_state_nxt = BUSY;
                        w_cnt_nxt   = (bus.mc_cycles == '0) ? CNT_ONE : bus.mc_cycles;
                    end
                end
                BUSY: begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) w_state_nxt = IDLE;
                end
                FLUSH:   w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.stall = 6'b000000;
        if (r_state == FLUSH)
            bus.stall = 6'b000000;
        else if (bus.excp_req)
            bus.stall = 6'b111111;
        else if ((r_state == IDLE && bus.mc_start) ||
                 (r_state == BUSY && r_cnt > CNT_ONE) || bus.stallreq_ex)
            bus.stall = 6'b001111;
        else if (bus.stallreq_id)
            bus.stall = 6'b000111;
    end

    assign bus.flush   = (r_state == FLUSH);
    assign bus.new_pc  = r_new_pc;
    assign bus.busy    = (r_state == BUSY);
    assign bus.mc_done = (r_state == BUSY) && (r_cnt == CNT_ONE);
endmodule
